// File: rtl/approx_mul_error_sweeper.sv
// approx_mul_error_sweeper
// Walks every operand pair through an approximate WIDTHxWIDTH multiplier, one pair per
// cycle, and accumulates the absolute error against an exact product: saturating sum,
// maximum, and count of pairs with a nonzero error.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; results hold; operands driven to 0
// SWEEP | issuing pair cnt; the last pair is issued at cnt = all ones
// DRAIN | no new pairs; waiting for the multiplier pipeline to empty
//
// A valid bit and a copy of the operands travel through a MUL_LAT+1 deep delay line.
// The exact product is formed from the copy at the tail of that line, so it lines up
// with mul_p. When the sweep ends, the FSM moves to IDLE on the same edge that
// accumulates the last pair. done therefore pulses in the first IDLE cycle, and the
// final results are already visible in that cycle.
module approx_mul_error_sweeper #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 0,
  parameter int ACC_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max,
  output logic [2*WIDTH:0]     err_cnt,
  output logic                 sat
);

  localparam int PW    = 2 * WIDTH;
  localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam int DW    = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    cnt;
  logic [PW-1:0]    cnt_inc;
  logic [DW-1:0]    drain_cnt;

  logic             vld_pipe [0:MUL_LAT];
  logic [WIDTH-1:0] a_pipe   [0:MUL_LAT];
  logic [WIDTH-1:0] b_pipe   [0:MUL_LAT];

  logic [PW-1:0]    exact;
  logic [PW:0]      diff;
  logic [PW-1:0]    err_abs;
  logic [SUM_W-1:0] sum_next;

  // Stage 0 of the delay line is the operand register that drives the multiplier.
  assign mul_a = a_pipe[0];
  assign mul_b = b_pipe[0];
  assign busy  = (state != S_IDLE);

  // Exact product of the aligned operands, absolute error, and the widened running sum.
  always_comb begin
    cnt_inc  = cnt + 1'b1;
    exact    = PW'(a_pipe[MUL_LAT]) * PW'(b_pipe[MUL_LAT]);
    diff     = {1'b0, exact} - {1'b0, mul_p};
    err_abs  = diff[PW] ? PW'(-diff) : diff[PW-1:0];
    sum_next = SUM_W'(err_sum) + SUM_W'(err_abs);
  end

  // Sequencer FSM, operand delay line and error accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      err_sum   <= '0;
      err_max   <= '0;
      err_cnt   <= '0;
      sat       <= 1'b0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        vld_pipe[k] <= 1'b0;
        a_pipe[k]   <= '0;
        b_pipe[k]   <= '0;
      end
    end else begin
      done <= 1'b0;

      for (int k = 1; k <= MUL_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        a_pipe[k]   <= a_pipe[k-1];
        b_pipe[k]   <= b_pipe[k-1];
      end
      vld_pipe[0] <= 1'b0;
      a_pipe[0]   <= '0;
      b_pipe[0]   <= '0;

      // An abort discards whatever is arriving at the tail on the same edge.
      if (vld_pipe[MUL_LAT] && !abort) begin
        if (sum_next > ACC_MAX) begin
          err_sum <= '1;
          sat     <= 1'b1;
        end else begin
          err_sum <= sum_next[ACC_W-1:0];
        end
        if (err_abs > err_max) err_max <= err_abs;
        if (err_abs != '0) err_cnt <= err_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SWEEP;
            cnt         <= '0;
            vld_pipe[0] <= 1'b1;
            err_sum     <= '0;
            err_max     <= '0;
            err_cnt     <= '0;
            sat         <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (abort) begin
            state <= S_IDLE;
            for (int k = 1; k <= MUL_LAT; k++) vld_pipe[k] <= 1'b0;
          end else if (cnt == {PW{1'b1}}) begin
            if (MUL_LAT == 0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DW'(MUL_LAT - 1);
            end
          end else begin
            cnt         <= cnt_inc;
            vld_pipe[0] <= 1'b1;
            a_pipe[0]   <= cnt_inc[WIDTH-1:0];
            b_pipe[0]   <= cnt_inc[PW-1:WIDTH];
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            for (int k = 1; k <= MUL_LAT; k++) vld_pipe[k] <= 1'b0;
          end else if (drain_cnt == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_error_sweeper.sv
// Bench for approx_mul_error_sweeper: two 4-bit instances (N = 256 pairs).
//   dut0: MUL_LAT=0, ACC_W=32, combinational stub multiplier
//   dut1: MUL_LAT=2, ACC_W=13, stub behind two registers (saturates on the all-zero stub)
// A cycle-indexed model derives the expected outputs of every cycle from the time since start.
module tb_approx_mul_error_sweeper;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [3:0] a0, b0, a1, b1;
  logic [7:0] p0, p1, pr1, pr2;
  logic       busy0, busy1, done0, done1, sat0, sat1;
  logic [31:0] sum0;
  logic [12:0] sum1;
  logic [7:0]  max0, max1;
  logic [8:0]  cnt0, cnt1;

  int mode = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: exact, 1: exact+1, 2: zero, 3: approximate (low bits OR-ed with a[0], b[0])
  function automatic logic [7:0] stub(input int m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] e;
    e = {4'b0, a} * {4'b0, b};
    case (m)
      0:       return e;
      1:       return e + 8'd1;
      2:       return 8'd0;
      default: return e | {6'b0, a[0], b[0]};
    endcase
  endfunction

  function automatic int err_of(input int m, input int a, input int b);
    int e, p;
    e = a * b;
    p = int'(stub(m, 4'(a), 4'(b)));
    return (e > p) ? e - p : p - e;
  endfunction

  assign p0 = stub(mode, a0, b0);
  always @(posedge clk) begin
    pr1 <= stub(mode, a1, b1);
    pr2 <= pr1;
  end
  assign p1 = pr2;

  approx_mul_error_sweeper #(.WIDTH(4), .MUL_LAT(0), .ACC_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mul_a(a0), .mul_b(b0), .mul_p(p0),
    .busy(busy0), .done(done0), .err_sum(sum0), .err_max(max0), .err_cnt(cnt0), .sat(sat0));

  approx_mul_error_sweeper #(.WIDTH(4), .MUL_LAT(2), .ACC_W(13)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mul_a(a1), .mul_b(b1), .mul_p(p1),
    .busy(busy1), .done(done1), .err_sum(sum1), .err_max(max1), .err_cnt(cnt1), .sat(sat1));

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Whole-sweep totals straight from the definition, used to pin the model.
  task automatic model_totals(input int m, output longint s, output longint mx, output longint c);
    int e;
    s = 0; mx = 0; c = 0;
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 16; a++) begin
        e = err_of(m, a, b);
        s += e;
        if (e > mx) mx = e;
        if (e != 0) c++;
      end
  endtask

  // Model state: mt = cycle index relative to the accepted start cycle (-1 = idle after reset/abort).
  int     mt   [2] = '{-1, -1};
  longint raw  [2] = '{0, 0};
  longint mmax [2] = '{0, 0};
  longint mcnt [2] = '{0, 0};
  int     lat  [2] = '{0, 2};
  longint maxv [2] = '{64'hFFFF_FFFF, 64'd8191};

  // Compare process: every cycle, mid-cycle, both instances.
  always @(negedge clk) begin
    logic       o_busy, o_done, o_sat;
    logic [3:0] o_a, o_b;
    longint     o_sum, o_max, o_cnt;
    bit         running;
    int         k, e, ea, eb;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        o_busy = busy0; o_done = done0; o_sat = sat0; o_a = a0; o_b = b0;
        o_sum = longint'(sum0); o_max = longint'(max0); o_cnt = longint'(cnt0);
      end else begin
        o_busy = busy1; o_done = done1; o_sat = sat1; o_a = a1; o_b = b1;
        o_sum = longint'(sum1); o_max = longint'(max1); o_cnt = longint'(cnt1);
      end
      if (!rst_n) begin
        mt[i] = -1; raw[i] = 0; mmax[i] = 0; mcnt[i] = 0;
      end
      running = (mt[i] >= 1) && (mt[i] <= N + lat[i]);
      if (mt[i] >= 1 && mt[i] <= N) begin
        ea = (mt[i] - 1) % 16; eb = (mt[i] - 1) / 16;
      end else begin
        ea = 0; eb = 0;
      end
      check("busy",    i, 64'(o_busy), 64'(running));
      check("done",    i, 64'(o_done), 64'(mt[i] == N + lat[i] + 1));
      check("mul_a",   i, 64'(o_a), 64'(ea));
      check("mul_b",   i, 64'(o_b), 64'(eb));
      check("err_sum", i, o_sum, (raw[i] > maxv[i]) ? maxv[i] : raw[i]);
      check("err_max", i, o_max, mmax[i]);
      check("err_cnt", i, o_cnt, mcnt[i]);
      check("sat",     i, 64'(o_sat), 64'(raw[i] > maxv[i]));
      if (rst_n) begin
        if (running && abort) begin
          mt[i] = -1;
        end else if (running) begin
          k = mt[i] - lat[i] - 1;
          if (k >= 0 && k < N) begin
            e = err_of(mode, k % 16, k / 16);
            raw[i] += e;
            if (e > mmax[i]) mmax[i] = e;
            if (e != 0) mcnt[i]++;
          end
          mt[i]++;
        end else if (start) begin
          mt[i] = 1; raw[i] = 0; mmax[i] = 0; mcnt[i] = 0;
        end else if (mt[i] == N + lat[i] + 1) begin
          mt[i] = N + lat[i] + 2;
        end
      end
    end
  end

  // One 400-cycle window: start in cycle 0, optional restart/abort/reset, and done-cycle capture.
  task automatic sweep(input int abort_at, input int restart_at, input int rst_at,
                       input bit abort_with_start, output int d0, output int d1);
    d0 = -1; d1 = -1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == restart_at);
      abort = (c == abort_at) || (abort_with_start && c == 0);
      if (rst_at >= 0 && c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
      if (done0 && d0 < 0) d0 = c;
      if (done1 && d1 < 0) d1 = c;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int d0, d1;
    longint s, mx, c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    model_totals(1, s, mx, c);
    check("pin_m1_sum", 0, 64'(s), 64'd256);
    check("pin_m1_max", 0, 64'(mx), 64'd1);
    check("pin_m1_cnt", 0, 64'(c), 64'd256);
    model_totals(2, s, mx, c);
    check("pin_m2_sum", 0, 64'(s), 64'd14400);
    check("pin_m2_max", 0, 64'(mx), 64'd225);
    check("pin_m2_cnt", 0, 64'(c), 64'd225);

    mode = 0;
    sweep(-1, -1, -1, 1'b0, d0, d1);
    check("exact_done_cycle", 0, 64'(d0), 64'd257);
    check("exact_done_cycle", 1, 64'(d1), 64'd259);
    check("exact_sum", 0, 64'(sum0), 64'd0);
    check("exact_cnt", 1, 64'(cnt1), 64'd0);

    mode = 1;
    sweep(-1, 50, -1, 1'b0, d0, d1);
    check("plus1_done_cycle", 0, 64'(d0), 64'd257);
    check("plus1_done_cycle", 1, 64'(d1), 64'd259);
    check("plus1_sum", 0, 64'(sum0), 64'd256);
    check("plus1_max", 0, 64'(max0), 64'd1);
    check("plus1_cnt", 0, 64'(cnt0), 64'd256);
    check("plus1_sum", 1, 64'(sum1), 64'd256);
    check("plus1_sat", 1, 64'(sat1), 64'd0);

    mode = 2;
    sweep(-1, -1, -1, 1'b0, d0, d1);
    check("zero_sum", 0, 64'(sum0), 64'd14400);
    check("zero_max", 0, 64'(max0), 64'd225);
    check("zero_cnt", 0, 64'(cnt0), 64'd225);
    check("zero_sat", 0, 64'(sat0), 64'd0);
    check("zero_sum_clamped", 1, 64'(sum1), 64'd8191);
    check("zero_sat", 1, 64'(sat1), 64'd1);

    mode = 3;
    sweep(-1, -1, -1, 1'b0, d0, d1);
    check("approx_done_cycle", 0, 64'(d0), 64'd257);
    check("approx_done_cycle", 1, 64'(d1), 64'd259);

    mode = 1;
    sweep(100, -1, -1, 1'b0, d0, d1);
    check("abort_no_done", 0, 64'(d0 < 0), 64'd1);
    check("abort_no_done", 1, 64'(d1 < 0), 64'd1);

    sweep(-1, -1, -1, 1'b1, d0, d1);
    check("start_abort_done_cycle", 0, 64'(d0), 64'd257);
    check("start_abort_sum", 0, 64'(sum0), 64'd256);

    mode = 2;
    sweep(-1, -1, 150, 1'b0, d0, d1);
    check("reset_no_done", 0, 64'(d0 < 0), 64'd1);
    check("reset_sum", 0, 64'(sum0), 64'd0);

    mode = 0;
    sweep(-1, -1, -1, 1'b0, d0, d1);
    check("recover_done_cycle", 0, 64'(d0), 64'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
